dcache_wb_ctrl: RTL and testbench

//  Parametrised set-associative, write-back, write-allocate data cache controller.

---
 rtl/dcache_wb_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_dcache_wb_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_ctrl.sv
// Set-associative write-back/write-allocate data cache controller between a CPU
// load/store port and a word-wide memory handshake, with flush walk and hit/miss counters.
module dcache_wb_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read,
    input  logic              write,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned OFF_W   = $clog2(BYTES);
    localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned TAG_W   = ADDR_W - IDX_W - WORD_W - OFF_W;
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned ENTRIES = SETS * WAYS;
    localparam int unsigned ENT_W   = $clog2(ENTRIES);
    localparam int unsigned DIDX_W  = $clog2(ENTRIES * LINE_WORDS);
    localparam int unsigned LINE_SH = WORD_W + OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_REFILL,
        S_FLUSH_SCAN,
        S_FLUSH_WB,
        S_FLUSH_DONE
    } state_e;

    state_e state_q, state_d;

    // Storage: data and tags are not reset, only the state bits are
    logic [DATA_W-1:0]  data_q [ENTRIES*LINE_WORDS];
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [ENTRIES-1:0] valid_q, dirty_q;
    logic [WAY_W-1:0]   rr_q   [SETS];

    logic [IDX_W-1:0]  set_q, set_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              req;
    logic              unused_addr_bits;

    assign req_tag  = address[ADDR_W-1 -: TAG_W];
    assign req_idx  = address[LINE_SH +: IDX_W];
    assign req_word = address[OFF_W +: WORD_W];
    assign req      = read | write;
    assign unused_addr_bits = ^address[OFF_W-1:0];

    logic              hit;
    logic [WAY_W-1:0]  hit_way, inv_way, vic_way;
    logic              inv_found;
    logic [ENT_W-1:0]  hit_ent, vic_ent, cur_ent;
    logic [DIDX_W-1:0] hit_didx, cur_didx;
    logic [DATA_W-1:0] hit_word;
    logic [ADDR_W-1:0] refill_base;

    // Tag compare across the ways of the addressed set; victim = first invalid, else round-robin
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[ENT_W'(req_idx * WAYS + w)]
                && (tag_q[ENT_W'(req_idx * WAYS + w)] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[ENT_W'(req_idx * WAYS + w)]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        vic_way = inv_found ? inv_way : rr_q[req_idx];
    end

    assign hit_ent     = ENT_W'(req_idx * WAYS + hit_way);
    assign vic_ent     = ENT_W'(req_idx * WAYS + vic_way);
    assign cur_ent     = ENT_W'(set_q * WAYS + way_q);
    assign hit_didx    = DIDX_W'(hit_ent * LINE_WORDS + req_word);
    assign cur_didx    = DIDX_W'(cur_ent * LINE_WORDS + beat_q);
    assign hit_word    = data_q[hit_didx];
    assign refill_base = ADDR_W'({req_tag, req_idx}) << LINE_SH;

    logic idle, lookup_hit, lookup_miss, last_beat, ack_last;
    logic refill_last, flush_wb_last, scan_drop, cur_dirty, scan_last;
    logic [WAY_W-1:0] rr_next;

    assign idle          = (state_q == S_IDLE);
    assign lookup_hit    = idle && !flush && req && hit;
    assign lookup_miss   = idle && !flush && req && !hit;
    assign last_beat     = (beat_q == WORD_W'(LINE_WORDS - 1));
    assign ack_last      = mem_ack && last_beat;
    assign cur_dirty     = valid_q[cur_ent] && dirty_q[cur_ent];
    assign refill_last   = (state_q == S_REFILL) && ack_last;
    assign flush_wb_last = (state_q == S_FLUSH_WB) && ack_last;
    assign scan_drop     = (state_q == S_FLUSH_SCAN) && !cur_dirty;
    assign scan_last     = (set_q == IDX_W'(SETS - 1)) && (way_q == WAY_W'(WAYS - 1));
    assign rr_next       = (rr_q[set_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_q] + WAY_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus walk/beat bookkeeping
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        way_d      = way_q;
        beat_d     = beat_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH_SCAN;
                    set_d   = '0;
                    way_d   = '0;
                end else if (lookup_miss) begin
                    set_d  = req_idx;
                    way_d  = vic_way;
                    beat_d = '0;
                    if (valid_q[vic_ent] && dirty_q[vic_ent]) begin
                        state_d    = S_WB;
                        mem_addr_d = ADDR_W'({tag_q[vic_ent], req_idx}) << LINE_SH;
                    end else begin
                        state_d    = S_REFILL;
                        mem_addr_d = refill_base;
                    end
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    beat_d = beat_q + WORD_W'(1);
                    if (last_beat) begin
                        state_d    = S_REFILL;
                        mem_addr_d = refill_base;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
                    end
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    beat_d = beat_q + WORD_W'(1);
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
                    end
                end
            end
            S_FLUSH_SCAN: begin
                if (cur_dirty) begin
                    state_d    = S_FLUSH_WB;
                    beat_d     = '0;
                    mem_addr_d = ADDR_W'({tag_q[cur_ent], set_q}) << LINE_SH;
                end else if (scan_last) begin
                    state_d = S_FLUSH_DONE;
                end else if (way_q == WAY_W'(WAYS - 1)) begin
                    way_d = '0;
                    set_d = set_q + IDX_W'(1);
                end else begin
                    way_d = way_q + WAY_W'(1);
                end
            end
            S_FLUSH_WB: begin
                if (mem_ack) begin
                    beat_d = beat_q + WORD_W'(1);
                    if (last_beat) begin
                        state_d = S_FLUSH_SCAN;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
                    end
                end
            end
            S_FLUSH_DONE: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // CPU and memory-port outputs; stall is forced low while reset is held
    always_comb begin
        stall      = 1'b0;
        rdata      = '0;
        flush_done = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                stall = flush || (req && !hit);
                if (!flush && read && !write && hit) begin
                    rdata = hit_word;
                end
            end
            S_WB, S_FLUSH_WB: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = data_q[cur_didx];
            end
            S_REFILL: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            S_FLUSH_SCAN: stall = 1'b1;
            S_FLUSH_DONE: begin
                stall      = 1'b1;
                flush_done = 1'b1;
            end
            default: stall = 1'b0;
        endcase
        if (!rst) begin
            stall = 1'b0;
        end
    end

    assign mem_addr = mem_addr_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Line state, replacement pointers, walk registers and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            set_q      <= '0;
            way_q      <= '0;
            beat_q     <= '0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            set_q      <= set_d;
            way_q      <= way_d;
            beat_q     <= beat_d;
            mem_addr_q <= mem_addr_d;
            if (lookup_hit && write) begin
                dirty_q[hit_ent] <= 1'b1;
            end
            if (refill_last) begin
                valid_q[cur_ent] <= 1'b1;
                dirty_q[cur_ent] <= 1'b0;
                rr_q[set_q]      <= rr_next;
            end
            if (flush_wb_last) begin
                dirty_q[cur_ent] <= 1'b0;
            end
            if (scan_drop) begin
                valid_q[cur_ent] <= 1'b0;
                dirty_q[cur_ent] <= 1'b0;
            end
            if (lookup_hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (lookup_miss && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    // Data/tag writes: store hits and refill beats
    always_ff @(posedge clk) begin
        if (lookup_hit && write) begin
            data_q[hit_didx] <= wdata;
        end
        if ((state_q == S_REFILL) && mem_ack) begin
            data_q[cur_didx] <= mem_rdata;
            if (last_beat) begin
                tag_q[cur_ent] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed bench for dcache_wb_ctrl: cold miss, hits, store, dirty eviction, flush and
// mid-refill reset against a memory that answers addr ^ 0xA5A5_0000.
module tb_dcache_wb_ctrl;

    logic        clk, rst;
    logic [31:0] address, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        read, write, flush, stall, flush_done, mem_req, mem_we, mem_ack;
    logic [15:0] hit_cnt, miss_cnt;

    dcache_wb_ctrl #(
        .ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(2), .LINE_WORDS(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata), .read(read),
        .write(write), .flush(flush), .rdata(rdata), .stall(stall),
        .flush_done(flush_done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks each beat two cycles after the request is seen
    logic wait_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ack   <= 1'b0;
            wait_q    <= 1'b0;
            mem_rdata <= '0;
        end else if (mem_ack) begin
            mem_ack <= 1'b0;
            wait_q  <= 1'b0;
        end else if (mem_req) begin
            if (wait_q) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem_addr ^ 32'hA5A5_0000;
                wait_q    <= 1'b0;
            end else begin
                wait_q <= 1'b1;
            end
        end
    end

    // Beat log of every completed memory transfer
    logic        log_we   [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int          log_n = 0;
    always @(posedge clk) begin
        if (rst && mem_req && mem_ack && log_n < 64) begin
            log_we[log_n]   <= mem_we;
            log_addr[log_n] <= mem_addr;
            log_data[log_n] <= mem_wdata;
            log_n           <= log_n + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int i, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
        check_eq($sformatf("%s_b%0d_we", tag, i), 64'(log_we[i]), 64'(we));
        check_eq($sformatf("%s_b%0d_addr", tag, i), 64'(log_addr[i]), 64'(a));
        if (we) begin
            check_eq($sformatf("%s_b%0d_data", tag, i), 64'(log_data[i]), 64'(d));
        end
    endtask

    // Issue one CPU access at a negedge; ncyc = stalled samples before it is accepted
    task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output int ncyc, output logic [31:0] rd_o);
        @(negedge clk);
        address = a;
        wdata   = wd;
        read    = rd;
        write   = wr;
        ncyc    = 0;
        #1;
        while (stall && ncyc < 400) begin
            ncyc++;
            @(negedge clk);
            #1;
        end
        if (stall) begin
            check_eq("cpu_timeout", 64'(stall), 64'd0);
        end
        rd_o = rdata;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        int          n, s, pulses, k;
        logic [31:0] rd;
        logic        stall_seen_low;

        rst = 1'b0; read = 1'b0; write = 1'b0; flush = 1'b0;
        address = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_flush_done", 64'(flush_done), 64'd0);
        check_eq("rst_rdata", 64'(rdata), 64'd0);
        check_eq("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check_eq("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Cold read miss
        s = log_n;
        cpu_op(1'b1, 1'b0, 32'h10, 32'h0, n, rd);
        check_eq("t1_stall_cycles", 64'(n), 64'd13);
        check_eq("t1_rdata", 64'(rd), 64'hA5A5_0010);
        check_eq("t1_nbeats", 64'(log_n - s), 64'd4);
        for (int i = 0; i < 4; i++) check_beat("t1", s + i, 1'b0, 32'h10 + 32'(4 * i), 32'h0);
        check_eq("t1_miss_cnt", 64'(miss_cnt), 64'd1);
        check_eq("t1_hit_cnt", 64'(hit_cnt), 64'd1);

        // Read hit in the same line
        s = log_n;
        cpu_op(1'b1, 1'b0, 32'h18, 32'h0, n, rd);
        check_eq("t2_stall_cycles", 64'(n), 64'd0);
        check_eq("t2_rdata", 64'(rd), 64'hA5A5_0018);
        check_eq("t2_nbeats", 64'(log_n - s), 64'd0);
        check_eq("t2_hit_cnt", 64'(hit_cnt), 64'd2);
        @(negedge clk);
        #1;
        check_eq("idle_stall", 64'(stall), 64'd0);
        check_eq("idle_mem_req", 64'(mem_req), 64'd0);

        // Store hit then read back
        s = log_n;
        cpu_op(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF, n, rd);
        check_eq("t3_wr_stall", 64'(n), 64'd0);
        cpu_op(1'b1, 1'b0, 32'h14, 32'h0, n, rd);
        check_eq("t3_rd_stall", 64'(n), 64'd0);
        check_eq("t3_rdata", 64'(rd), 64'hDEAD_BEEF);
        check_eq("t3_nbeats", 64'(log_n - s), 64'd0);
        check_eq("t3_hit_cnt", 64'(hit_cnt), 64'd4);

        // Fill second way, then evict the dirty line at 0x10
        s = log_n;
        cpu_op(1'b1, 1'b0, 32'h110, 32'h0, n, rd);
        check_eq("t4a_stall_cycles", 64'(n), 64'd13);
        check_eq("t4a_rdata", 64'(rd), 64'hA5A5_0110);
        check_eq("t4a_nbeats", 64'(log_n - s), 64'd4);
        for (int i = 0; i < 4; i++) check_beat("t4a", s + i, 1'b0, 32'h110 + 32'(4 * i), 32'h0);
        s = log_n;
        cpu_op(1'b1, 1'b0, 32'h210, 32'h0, n, rd);
        check_eq("t4b_stall_cycles", 64'(n), 64'd25);
        check_eq("t4b_rdata", 64'(rd), 64'hA5A5_0210);
        check_eq("t4b_nbeats", 64'(log_n - s), 64'd8);
        check_beat("t4b", s + 0, 1'b1, 32'h10, 32'hA5A5_0010);
        check_beat("t4b", s + 1, 1'b1, 32'h14, 32'hDEAD_BEEF);
        check_beat("t4b", s + 2, 1'b1, 32'h18, 32'hA5A5_0018);
        check_beat("t4b", s + 3, 1'b1, 32'h1C, 32'hA5A5_001C);
        for (int i = 0; i < 4; i++) check_beat("t4b", s + 4 + i, 1'b0, 32'h210 + 32'(4 * i), 32'h0);
        check_eq("t4_miss_cnt", 64'(miss_cnt), 64'd3);
        check_eq("t4_hit_cnt", 64'(hit_cnt), 64'd6);

        // Dirty 0x110 then flush
        cpu_op(1'b0, 1'b1, 32'h110, 32'h1234_5678, n, rd);
        check_eq("t5_wr_stall", 64'(n), 64'd0);
        s = log_n;
        @(negedge clk);
        flush = 1'b1;
        #1;
        check_eq("t5_stall_at_flush", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        flush  = 1'b0;
        pulses = 0;
        k      = 0;
        stall_seen_low = 1'b0;
        while (!stall_seen_low && k < 1000) begin
            @(negedge clk);
            #1;
            if (flush_done) pulses++;
            if (!stall) stall_seen_low = 1'b1;
            k++;
        end
        check_eq("t5_flush_ended", 64'(stall), 64'd0);
        check_eq("t5_flush_done_pulses", 64'(pulses), 64'd1);
        check_eq("t5_nbeats", 64'(log_n - s), 64'd4);
        check_beat("t5", s + 0, 1'b1, 32'h110, 32'h1234_5678);
        check_beat("t5", s + 1, 1'b1, 32'h114, 32'hA5A5_0114);
        check_beat("t5", s + 2, 1'b1, 32'h118, 32'hA5A5_0118);
        check_beat("t5", s + 3, 1'b1, 32'h11C, 32'hA5A5_011C);
        s = log_n;
        cpu_op(1'b1, 1'b0, 32'h110, 32'h0, n, rd);
        check_eq("t5_post_stall_cycles", 64'(n), 64'd13);
        check_eq("t5_post_rdata", 64'(rd), 64'hA5A5_0110);
        check_eq("t5_post_nbeats", 64'(log_n - s), 64'd4);
        check_eq("t5_miss_cnt", 64'(miss_cnt), 64'd4);

        // Reset after the second refill ack
        s = log_n;
        @(negedge clk);
        address = 32'h400;
        read    = 1'b1;
        k = 0;
        while (log_n < s + 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("t6_two_acks", 64'(log_n - s), 64'd2);
        rst = 1'b0;
        #1;
        check_eq("t6_rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("t6_rst_stall", 64'(stall), 64'd0);
        check_eq("t6_rst_rdata", 64'(rdata), 64'd0);
        check_eq("t6_rst_miss_cnt", 64'(miss_cnt), 64'd0);
        check_eq("t6_rst_hit_cnt", 64'(hit_cnt), 64'd0);
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        s = log_n;
        cpu_op(1'b1, 1'b0, 32'h400, 32'h0, n, rd);
        check_eq("t6_stall_cycles", 64'(n), 64'd13);
        check_eq("t6_rdata", 64'(rd), 64'hA5A5_0400);
        check_eq("t6_nbeats", 64'(log_n - s), 64'd4);
        for (int i = 0; i < 4; i++) check_beat("t6", s + i, 1'b0, 32'h400 + 32'(4 * i), 32'h0);
        check_eq("t6_miss_cnt", 64'(miss_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

endmodule
